// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: owns the PC, issues instruction-memory reads, queues {pc, instr} for decode
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect yields a pre-filled trapping NOP entry)

module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  output logic [XLEN-1:0] o_im_araddr,
  input  logic            i_im_rvalid,
  input  logic [XLEN-1:0] i_im_rdata,
  output logic            o_im_rready,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            o_if_misalign,
`endif
  output logic [XLEN-1:0] o_if_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [DEPTH-1:0] q_filled;
  logic [PW-1:0]   alloc_ptr, fill_ptr, head_ptr, discard_cnt;
  logic [PW-1:0]   occupancy, outstanding, discard_next;
  logic [PW:0]     inflight, pend_total;
  logic [AW-1:0]   alloc_idx, fill_idx, head_idx;
  logic [XLEN-1:0] redirect_target;
  logic            stalled, accept, pop, rsp_drop, rsp_fill;

  assign occupancy   = alloc_ptr - head_ptr;
  assign outstanding = alloc_ptr - fill_ptr;
  assign alloc_idx   = alloc_ptr[AW-1:0];
  assign fill_idx    = fill_ptr[AW-1:0];
  assign head_idx    = head_ptr[AW-1:0];

  // Stale responses still owed by memory count against the queue so discard_cnt never exceeds DEPTH.
  assign inflight = {1'b0, occupancy} + {1'b0, discard_cnt};

  assign o_im_arvalid = !rst && !i_redirect && !stalled && (inflight < DEPTH_W);
  assign o_im_araddr  = pc;
  assign o_im_rready  = 1'b1;
  assign accept       = o_im_arvalid && i_im_arready;

  assign o_if_valid = q_filled[head_idx] && (occupancy != '0);
  assign o_if_instr = q_instr[head_idx];
  assign o_if_pc    = q_pc[head_idx];
  assign pop        = o_if_valid && i_if_ready;

  assign rsp_drop = i_im_rvalid && (discard_cnt != '0);
  assign rsp_fill = i_im_rvalid && (discard_cnt == '0) && (outstanding != '0);

  // Everything still owed by memory becomes stale on redirect; a response arriving now settles one of them.
  assign pend_total = {1'b0, discard_cnt} + {1'b0, outstanding};
  always_comb begin
    discard_next = PW'(pend_total);
    if (i_im_rvalid && (pend_total != '0))
      discard_next = PW'(pend_total - (PW+1)'(1));
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic redirect_misalign;
  assign redirect_misalign = |i_redirect_pc[1:0];
  assign redirect_target   = i_redirect_pc;
  assign o_if_misalign     = stalled && o_if_valid;
`else
  assign redirect_target = i_redirect_pc & ~XLEN'(3);
  assign stalled         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      discard_cnt <= '0;
      q_filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      stalled <= 1'b0;
`endif
    end else if (i_redirect) begin
      pc          <= redirect_target;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      discard_cnt <= discard_next;
      q_filled    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      stalled <= redirect_misalign;
      if (redirect_misalign) begin
        q_pc[0]     <= i_redirect_pc;
        q_instr[0]  <= XLEN'(32'h0000_0013);
        q_filled[0] <= 1'b1;
        alloc_ptr   <= PW'(1);
        fill_ptr    <= PW'(1);
      end
`endif
    end else begin
      if (accept) begin
        q_pc[alloc_idx]     <= pc;
        q_filled[alloc_idx] <= 1'b0;
        alloc_ptr           <= alloc_ptr + PW'(1);
        pc                  <= pc + XLEN'(4);
      end
      if (rsp_drop)
        discard_cnt <= discard_cnt - PW'(1);
      if (rsp_fill) begin
        q_instr[fill_idx]  <= i_im_rdata;
        q_filled[fill_idx] <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (pop)
        head_ptr <= head_ptr + PW'(1);
    end
  end

  // A response with nothing outstanding and nothing to discard is a memory protocol error.
  rsp_expected_a: assert property (@(posedge clk) disable iff (rst)
    i_im_rvalid |-> ((discard_cnt != '0) || (outstanding != '0)));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch with an in-order memory model

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_im_arvalid;
  logic        i_im_arready = 1'b0;
  logic [31:0] o_im_araddr;
  logic        i_im_rvalid = 1'b0;
  logic [31:0] i_im_rdata = '0;
  logic        o_im_rready;
  logic        o_if_valid;
  logic        i_if_ready = 1'b0;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_if_misalign;
`endif

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_im_arvalid(o_im_arvalid), .i_im_arready(i_im_arready), .o_im_araddr(o_im_araddr),
    .i_im_rvalid(i_im_rvalid), .i_im_rdata(i_im_rdata), .o_im_rready(o_im_rready),
    .o_if_valid(o_if_valid), .i_if_ready(i_if_ready), .o_if_instr(o_if_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_if_misalign(o_if_misalign),
`endif
    .o_if_pc(o_if_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses, per-request random latency within [lat_min, lat_max].
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        mq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1;
  int          arready_pct = 100;
  int          accepts = 0;
  logic [31:0] key = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ key;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #2;
    if (rst) begin
      mq.delete();
      last_due    = cyc;
      i_im_rvalid = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_im_rvalid = 1'b1;
      i_im_rdata  = memf(mq[0].addr);
    end else begin
      i_im_rvalid = 1'b0;
    end
    i_im_arready = ($urandom_range(99) < arready_pct);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (i_im_rvalid && mq.size() > 0) void'(mq.pop_front());
      if (o_im_arvalid && i_im_arready) begin
        int d;
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{o_im_araddr, d});
        accepts++;
      end
    end
  end

  // Reference model: after each redirect decode must see target, target+4, ... with instr = mem[pc].
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] next_pc = '0;
  bit          stalled_m = 1'b0;
  int          hs = 0;

  task automatic topup();
    while (!stalled_m && exp_q.size() < 8) begin
      exp_q.push_back('{next_pc, memf(next_pc), 1'b0});
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Monitor: pops the scoreboard on every accepted instruction; also checks request stability.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_if_valid && i_if_ready && !i_redirect) begin
        hs++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(o_if_pc), 64'hdead_beef);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("if_pc", 64'(o_if_pc), 64'(e.pc));
          check("if_instr", 64'(o_if_instr), 64'(e.instr));
`ifdef FETCH_MISALIGN_TRAP_EN
          check("if_misalign", 64'(o_if_misalign), 64'(e.mis));
`endif
        end
      end
      if (prev_hold && !i_redirect) begin
        check("arvalid_hold", 64'(o_im_arvalid), 64'd1);
        check("araddr_hold", 64'(o_im_araddr), 64'(prev_addr));
      end
      prev_hold = o_im_arvalid && !i_im_arready;
      prev_addr = o_im_araddr;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect(input logic [31:0] t);
    i_redirect    = 1'b1;
    i_redirect_pc = t;
    exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) begin
      exp_q.push_back('{t, 32'h0000_0013, 1'b1});
      stalled_m = 1'b1;
    end else begin
      next_pc   = t;
      stalled_m = 1'b0;
    end
`else
    next_pc   = {t[31:2], 2'b00};
    stalled_m = 1'b0;
`endif
    topup();
    tick();
    i_redirect = 1'b0;
  endtask

  task automatic wait_hs(input string name, input int n, input int budget);
    int h0;
    h0 = hs;
    for (int i = 0; i < budget && (hs - h0) < n; i++) tick();
    check(name, 64'((hs - h0) >= n), 64'd1);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    i_redirect = 1'b0;
    ticks(2);
    check("rst_arvalid", 64'(o_im_arvalid), 64'd0);
    check("rst_araddr", 64'(o_im_araddr), 64'h0);
    check("rst_if_valid", 64'(o_if_valid), 64'd0);
    check("rst_if_instr", 64'(o_if_instr), 64'h0);
    check("rst_if_pc", 64'(o_if_pc), 64'h0);
    check("rst_rready", 64'(o_im_rready), 64'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misalign", 64'(o_if_misalign), 64'd0);
`endif
    exp_q.delete();
    next_pc   = 32'h0;
    stalled_m = 1'b0;
    accepts   = 0;
    topup();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    logic [31:0] t;

    // Streaming, 1-cycle memory returning addr as data: one instruction per cycle.
    key = '0; lat_min = 1; lat_max = 1; arready_pct = 100; i_if_ready = 1'b1;
    do_reset();
    ticks(5);
    h0 = hs;
    ticks(10);
    check("throughput", 64'(hs - h0), 64'd10);

    // Decode stalled: exactly DEPTH requests, then in-order release.
    i_if_ready = 1'b0;
    do_reset();
    ticks(10);
    check("stall_accepts", 64'(accepts), 64'd4);
    check("stall_arvalid", 64'(o_im_arvalid), 64'd0);
    i_if_ready = 1'b1;
    wait_hs("stall_release", 5, 40);

    // arready low for three cycles while fetching 0x8.
    key = 32'h5a5a_0f0f;
    do_reset();
    ticks(2);
    arready_pct = 0;
    for (int k = 0; k < 3; k++) begin
      check("ar_stall_addr", 64'(o_im_araddr), 64'h8);
      check("ar_stall_valid", 64'(o_im_arvalid), 64'd1);
      tick();
    end
    arready_pct = 100;
    check("ar_resume_addr", 64'(o_im_araddr), 64'h8);
    wait_hs("ar_resume", 6, 40);

    // 3-cycle memory, three outstanding, redirect: stale responses must be dropped.
    key = 32'h1234_5678; lat_min = 3; lat_max = 3;
    do_reset();
    ticks(3);
    redirect(32'h0000_0100);
    wait_hs("redir_outstanding", 4, 60);

    // Redirect colliding with pop and rvalid, then a PC wrap and a misaligned target.
    key = 32'hcafe_f00d; lat_min = 1; lat_max = 1;
    do_reset();
    ticks(8);
    #2;
    check("collide_setup", 64'({o_if_valid, i_im_rvalid}), 64'h3);
    redirect(32'h0000_0400);
    wait_hs("redir_collide", 4, 40);
    redirect(32'hffff_fff8);
    wait_hs("redir_wrap", 6, 40);
`ifndef FETCH_MISALIGN_TRAP_EN
    redirect(32'h0000_0102);
    wait_hs("redir_force_align", 3, 40);
`else
    i_if_ready = 1'b0;
    do_reset();
    ticks(3);
    redirect(32'h0000_0102);
    check("mis_valid", 64'(o_if_valid), 64'd1);
    check("mis_pc", 64'(o_if_pc), 64'h102);
    check("mis_flag", 64'(o_if_misalign), 64'd1);
    check("mis_instr", 64'(o_if_instr), 64'h13);
    check("mis_arvalid", 64'(o_im_arvalid), 64'd0);
    i_if_ready = 1'b1;
    ticks(3);
    check("mis_stall_arvalid", 64'(o_im_arvalid), 64'd0);
    check("mis_drained", 64'(o_if_valid), 64'd0);
    redirect(32'h0000_0200);
    wait_hs("mis_resume", 3, 40);
`endif

    // Randomized traffic: random latency, arready, decode backpressure and redirects.
    key = $urandom; lat_min = 1; lat_max = 4; arready_pct = 70;
    do_reset();
    h0 = hs;
    for (int i = 0; i < 3000; i++) begin
      i_if_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) begin
        t = $urandom;
        if ($urandom_range(7) != 0) t[1:0] = 2'b00;
        redirect(t);
      end else begin
        tick();
      end
    end
    check("random_liveness", 64'((hs - h0) > 200), 64'd1);
    i_if_ready = 1'b1; arready_pct = 100;
    redirect(32'h0000_1000);
    wait_hs("final_stream", 8, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
